// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: register-file geometry and common types.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  // Register $0 is hard-wired to zero in MIPS32.
  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : mips_pkg

// File: rtl/reg_file.sv
// MIPS32 general-purpose register file.
// One writeback port, two combinational decode read ports with same-cycle
// writeback-to-decode bypass, one un-bypassed debug read port, and a counter
// of committed non-$0 writes.
module reg_file
  import mips_pkg::*;
#(
  parameter int NUM_REGS = mips_pkg::NUM_REGS,
  parameter int DATA_W   = mips_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write_w,
  input  logic [REG_ADDR_W-1:0] write_reg_w,
  input  logic [DATA_W-1:0]     result_w,
  input  logic [REG_ADDR_W-1:0] read_reg1_d,
  input  logic [REG_ADDR_W-1:0] read_reg2_d,
  output logic [DATA_W-1:0]     read_data1_d,
  output logic [DATA_W-1:0]     read_data2_d,
  input  logic [REG_ADDR_W-1:0] dbg_reg,
  output logic [DATA_W-1:0]     dbg_data,
  output logic [31:0]           wb_count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [31:0]       wb_count_q;
  logic [31:0]       wb_count_d;
  logic              wr_en;

  // A write commits only outside reset and never to $0.
  assign wr_en = !rst && reg_write_w && (write_reg_w != ZERO_REG);

  // Shared read mux for the decode ports: $0, then bypass, then storage.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [DATA_W-1:0]     stored,
    input logic                  byp_en,
    input logic [REG_ADDR_W-1:0] byp_addr,
    input logic [DATA_W-1:0]     byp_data
  );
    if (addr == ZERO_REG) begin
      return '0;
    end else if (byp_en && (addr == byp_addr)) begin
      return byp_data;
    end else begin
      return stored;
    end
  endfunction

  // Next-state of storage and commit counter.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path can leave it unassigned and infer a latch.
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (rst) begin
      // NOTE: the storage array is cleared by reset on purpose; architectural state must read 0 after reset, so this memory is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
      wb_count_d = '0;
    end else if (wr_en) begin
      regs_d[write_reg_w] = result_w;
      wb_count_d          = wb_count_q + 32'd1;
    end
  end

  // State registers; reset is folded into the _d logic, so it stays synchronous.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    regs_q     <= regs_d;
    wb_count_q <= wb_count_d;
  end

  // Combinational read ports; the debug port sees storage only.
  always_comb begin
    read_data1_d = read_port(read_reg1_d, regs_q[read_reg1_d], wr_en, write_reg_w, result_w);
    read_data2_d = read_port(read_reg2_d, regs_q[read_reg2_d], wr_en, write_reg_w, result_w);
    dbg_data     = (dbg_reg == ZERO_REG) ? '0 : regs_q[dbg_reg];
  end

  assign wb_count = wb_count_q;

endmodule : reg_file
